// File: rtl/branch_resolve_if.sv
// Execute-stage branch inputs and fetch-side redirect outputs; 0-cycle wiring only.
// The slave modport belongs to the resolver, the master modport to its driver.
interface branch_resolve_if;
    logic        stall;
    logic        ex_valid;
    logic [1:0]  ex_op;
    logic [31:0] ex_pc;
    logic [15:0] ex_imm;
    logic [25:0] ex_jaddr;
    logic [31:0] cne_result;
    logic [31:0] pc;
    logic        redirect;
    logic        flush;
    logic [15:0] taken_count;

    modport master (
        output stall, ex_valid, ex_op, ex_pc, ex_imm, ex_jaddr, cne_result,
        input  pc, redirect, flush, taken_count
    );

    modport slave (
        input  stall, ex_valid, ex_op, ex_pc, ex_imm, ex_jaddr, cne_result,
        output pc, redirect, flush, taken_count
    );
endinterface

// File: rtl/branch_resolve.sv
// Resolves BEQ/BNE/J at execute and steers the fetch PC; 1-cycle latency from resolving edge.
// stall freezes all state (redirect drops); a taken redirect squashes younger work for FLUSH_CYCLES.
module branch_resolve #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    branch_resolve_if.slave br
);
    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        redirect_q, redirect_d;
    logic        flush_q, flush_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;

    logic [31:0] ex_pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] target;
    logic        cond_taken;
    logic        unused_cne;

    assign unused_cne  = ^br.cne_result[31:1];
    assign ex_pc_plus4 = br.ex_pc + 32'd4;
    assign br_target   = ex_pc_plus4 + {{14{br.ex_imm[15]}}, br.ex_imm, 2'b00};
    assign j_target    = {ex_pc_plus4[31:28], br.ex_jaddr, 2'b00};
    assign target      = (br.ex_op == 2'b11) ? j_target : br_target;

    always_comb begin
        cond_taken = 1'b0;
        case (br.ex_op)
            2'b01:   cond_taken = ~br.cne_result[0];
            2'b10:   cond_taken = br.cne_result[0];
            2'b11:   cond_taken = 1'b1;
            default: cond_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_d        = pc_q;
        redirect_d  = 1'b0;
        flush_d     = flush_q;
        taken_cnt_d = taken_cnt_q;
        if (!br.stall) begin
            case (state_q)
                RUN: begin
                    if (br.ex_valid && cond_taken) begin
                        pc_d       = target;
                        redirect_d = 1'b1;
                        flush_d    = 1'b1;
                        cnt_d      = CNT_INIT;
                        state_d    = FLUSH;
                        if (taken_cnt_q != 16'hFFFF)
                            taken_cnt_d = taken_cnt_q + 16'd1;
                    end else begin
                        pc_d    = pc_q + 32'd4;
                        flush_d = 1'b0;
                    end
                end
                FLUSH: begin
                    // Execute-stage inputs here belong to squashed shadow instructions.
                    pc_d = pc_q + 32'd4;
                    if (cnt_q == 2'd0) begin
                        flush_d = 1'b0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= 2'd0;
            pc_q        <= RESET_PC;
            redirect_q  <= 1'b0;
            flush_q     <= 1'b0;
            taken_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            redirect_q  <= redirect_d;
            flush_q     <= flush_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign br.pc          = pc_q;
    assign br.redirect    = redirect_q;
    assign br.flush       = flush_q;
    assign br.taken_count = taken_cnt_q;
endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: inputs change and outputs are checked on the falling edge.
module tb_branch_resolve;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    branch_resolve_if bif();

    branch_resolve #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .br    (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_pc, input logic e_rd,
                           input logic e_fl, input logic [15:0] e_tc);
        chk({tag, ".pc"},          bif.pc,                  e_pc);
        chk({tag, ".redirect"},    {31'd0, bif.redirect},   {31'd0, e_rd});
        chk({tag, ".flush"},       {31'd0, bif.flush},      {31'd0, e_fl});
        chk({tag, ".taken_count"}, {16'd0, bif.taken_count}, {16'd0, e_tc});
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] epc,
                         input logic [15:0] imm, input logic [25:0] ja, input logic cne);
        bif.ex_valid   = v;
        bif.ex_op      = op;
        bif.ex_pc      = epc;
        bif.ex_imm     = imm;
        bif.ex_jaddr   = ja;
        bif.cne_result = {31'h7FFF_FFFF, cne};
    endtask

    initial begin
        rst_n     = 1'b0;
        bif.stall = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk_out("reset", 32'h0, 1'b0, 1'b0, 16'd0);

        // Idle run from reset
        rst_n = 1'b1;
        @(negedge clk); chk_out("idle1", 32'h4, 1'b0, 1'b0, 16'd0);
        @(negedge clk); chk_out("idle2", 32'h8, 1'b0, 1'b0, 16'd0);
        @(negedge clk); chk_out("idle3", 32'hC, 1'b0, 1'b0, 16'd0);

        // BNE taken: 0x104 + 0x10
        drive(1'b1, 2'b10, 32'h100, 16'h0004, 26'h0, 1'b1);
        @(negedge clk); chk_out("bne_taken", 32'h114, 1'b1, 1'b1, 16'd1);
        drive(1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 1'b0);
        @(negedge clk); chk_out("bne_flush2", 32'h118, 1'b0, 1'b1, 16'd1);
        @(negedge clk); chk_out("bne_run", 32'h11C, 1'b0, 1'b0, 16'd1);

        // BEQ taken backwards: 0x204 - 8
        drive(1'b1, 2'b01, 32'h200, 16'hFFFE, 26'h0, 1'b0);
        @(negedge clk); chk_out("beq_taken", 32'h1FC, 1'b1, 1'b1, 16'd2);
        drive(1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 1'b0);
        @(negedge clk); chk_out("beq_flush2", 32'h200, 1'b0, 1'b1, 16'd2);
        @(negedge clk); chk_out("beq_run", 32'h204, 1'b0, 1'b0, 16'd2);
        drive(1'b1, 2'b01, 32'h200, 16'hFFFE, 26'h0, 1'b1);
        @(negedge clk); chk_out("beq_not_taken", 32'h208, 1'b0, 1'b0, 16'd2);

        // Jump, then a taken-looking BNE in the flush shadow
        drive(1'b1, 2'b11, 32'hF000_0010, 16'h0, 26'h0000040, 1'b0);
        @(negedge clk); chk_out("jump", 32'hF000_0100, 1'b1, 1'b1, 16'd3);
        drive(1'b1, 2'b10, 32'h100, 16'h0004, 26'h0, 1'b1);
        @(negedge clk); chk_out("shadow1", 32'hF000_0104, 1'b0, 1'b1, 16'd3);
        @(negedge clk); chk_out("shadow2", 32'hF000_0108, 1'b0, 1'b0, 16'd3);

        // Stall with a taken BNE pending: 0x304 + 0x40
        bif.stall = 1'b1;
        drive(1'b1, 2'b10, 32'h300, 16'h0010, 26'h0, 1'b1);
        @(negedge clk); chk_out("stall1", 32'hF000_0108, 1'b0, 1'b0, 16'd3);
        @(negedge clk); chk_out("stall2", 32'hF000_0108, 1'b0, 1'b0, 16'd3);
        @(negedge clk); chk_out("stall3", 32'hF000_0108, 1'b0, 1'b0, 16'd3);
        bif.stall = 1'b0;
        @(negedge clk); chk_out("stall_release", 32'h344, 1'b1, 1'b1, 16'd4);
        drive(1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 1'b0);
        @(negedge clk); chk_out("pre_reset_flush", 32'h348, 1'b0, 1'b1, 16'd4);

        // Reset mid-flush, with stall also asserted
        rst_n     = 1'b0;
        bif.stall = 1'b1;
        @(negedge clk); chk_out("reset_in_flush", 32'h0, 1'b0, 1'b0, 16'd0);
        rst_n     = 1'b1;
        bif.stall = 1'b0;
        @(negedge clk); chk_out("post_reset", 32'h4, 1'b0, 1'b0, 16'd0);

        // Taken branch whose target equals the fall-through
        drive(1'b1, 2'b01, 32'h40, 16'h0000, 26'h0, 1'b0);
        @(negedge clk); chk_out("self_target", 32'h44, 1'b1, 1'b1, 16'd1);
        drive(1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 1'b0);
        @(negedge clk);
        @(negedge clk); chk_out("self_target_run", 32'h4C, 1'b0, 1'b0, 16'd1);

        // Counter preloaded near saturation while stalled, saving 65k taken branches
        bif.stall = 1'b1;
        @(negedge clk);
        force dut.taken_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.taken_cnt_q;
        @(negedge clk); chk_out("preload_hold", 32'h4C, 1'b0, 1'b0, 16'hFFFE);
        bif.stall = 1'b0;
        drive(1'b1, 2'b11, 32'h0000_0010, 16'h0, 26'h0000100, 1'b0);
        @(negedge clk); chk_out("sat_reach", 32'h400, 1'b1, 1'b1, 16'hFFFF);
        @(negedge clk);
        @(negedge clk); chk_out("sat_run", 32'h408, 1'b0, 1'b0, 16'hFFFF);
        @(negedge clk); chk_out("sat_hold", 32'h400, 1'b1, 1'b1, 16'hFFFF);
        drive(1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
